// File: rtl/ov7670_capture_if.sv
// Bundle of OV7670 pin-side inputs and frame-buffer write-side outputs for ov7670_capture.
interface ov7670_capture_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              start_capture;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic [15:0]       pixel;
  logic              pixel_valid;
  logic [ADDR_W-1:0] pixel_addr;
  logic              frame_start;
  logic              frame_done;
  logic              frame_error;
  logic              capturing;

  modport slave (
    input  start_capture, cam_vsync, cam_href, cam_data,
    output pixel, pixel_valid, pixel_addr, frame_start, frame_done, frame_error, capturing
  );

  modport master (
    output start_capture, cam_vsync, cam_href, cam_data,
    input  pixel, pixel_valid, pixel_addr, frame_start, frame_done, frame_error, capturing
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus capture: pairs bytes into RGB565 pixels with linear frame-buffer addresses
// and frame start/done/error framing. Capture only arms during vertical blanking.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic             clk,
  input  logic             reset,
  ov7670_capture_if.slave  bus
);

  localparam int unsigned X_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W   = $clog2(V_ACTIVE + 1);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SYNC   = 2'd1;
  localparam logic [1:0] ARMED  = 2'd2;
  localparam logic [1:0] ACTIVE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic             vs_r, hr_r, vs_q, hr_q;
  logic [7:0]       d_r, hi_byte;
  logic             phase, err;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [CNT_W-1:0] pix_cnt;

  logic [15:0]       pix_data;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic              start_pulse, done_pulse, err_flag, cap;

  logic vs_rise, vs_fall, hr_fall, y_over, x_full;

  assign vs_rise = vs_r & ~vs_q;
  assign vs_fall = ~vs_r & vs_q;
  assign hr_fall = ~hr_r & hr_q;
  assign y_over  = (y >= Y_W'(V_ACTIVE));
  assign x_full  = (x == X_W'(H_ACTIVE));

  // Pin sampling stage plus one extra tap for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_r <= 1'b0;
      hr_r <= 1'b0;
      d_r  <= 8'd0;
      vs_q <= 1'b0;
      hr_q <= 1'b0;
    end else begin
      vs_r <= bus.cam_vsync;
      hr_r <= bus.cam_href;
      d_r  <= bus.cam_data;
      vs_q <= vs_r;
      hr_q <= hr_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A frame in progress always runs to frame_done; only SYNC/ARMED react to start dropping.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_capture) state_nxt = SYNC;
      SYNC:    if (!bus.start_capture) state_nxt = IDLE;
               else if (vs_r)          state_nxt = ARMED;
      ARMED:   if (!bus.start_capture) state_nxt = IDLE;
               else if (vs_fall)       state_nxt = ACTIVE;
      ACTIVE:  if (vs_rise) state_nxt = bus.start_capture ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_byte     <= 8'd0;
      phase       <= 1'b0;
      err         <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_cnt     <= '0;
      pix_data    <= 16'd0;
      pix_valid   <= 1'b0;
      pix_addr    <= '0;
      start_pulse <= 1'b0;
      done_pulse  <= 1'b0;
      err_flag    <= 1'b0;
      cap         <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      start_pulse <= 1'b0;
      done_pulse  <= 1'b0;
      cap         <= (state_nxt == ARMED) || (state_nxt == ACTIVE);
      case (state)
        ARMED: begin
          if (state_nxt == ACTIVE) begin
            start_pulse <= 1'b1;
            x           <= '0;
            y           <= '0;
            pix_cnt     <= '0;
            pix_addr    <= '0;
            phase       <= 1'b0;
            err         <= 1'b0;
            err_flag    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            done_pulse <= 1'b1;
            err_flag   <= err | (pix_cnt != CNT_W'(TOTAL));
          end else if (hr_r) begin
            phase <= ~phase;
            if (y_over) err <= 1'b1;
            if (!phase) begin
              hi_byte <= d_r;
            end else if (!y_over) begin
              // Pixels past the line width are dropped so the address cannot run ahead.
              if (x_full) begin
                err <= 1'b1;
              end else begin
                pix_data  <= {hi_byte, d_r};
                pix_valid <= 1'b1;
                pix_addr  <= pix_cnt[ADDR_W-1:0];
                pix_cnt   <= pix_cnt + 1'b1;
                x         <= x + 1'b1;
              end
            end
          end else if (hr_fall) begin
            if (!y_over) y <= y + 1'b1;
            x     <= '0;
            phase <= 1'b0;
            if (phase) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pixel       = pix_data;
  assign bus.pixel_valid = pix_valid;
  assign bus.pixel_addr  = pix_addr;
  assign bus.frame_start = start_pulse;
  assign bus.frame_done  = done_pulse;
  assign bus.frame_error = err_flag;
  assign bus.capturing   = cap;

endmodule

// File: doc/ov7670_capture.md
Name: ov7670_capture

Overview:
- Downstream consumer of the camera controller's start_capture flag.
- Samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]) and assembles byte pairs into RGB565 pixels.
- Emits each pixel with a linear frame-buffer write address, plus frame start/done pulses and a per-frame error flag.
- Sits between the camera pins and the frame-buffer write port.

Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- ADDR_W, 19: pixel_addr width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- clk  input  1  Camera PCLK (buffered). All logic samples on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- start_capture  input  1  Level from the controller; capture is enabled while high.
- cam_vsync  input  1  OV7670 VSYNC; high during vertical blanking.
- cam_href  input  1  OV7670 HREF; high while line data is valid.
- cam_data  input  8  OV7670 D[7:0].
- pixel  output  16  RGB565 pixel, {first byte, second byte}.
- pixel_valid  output  1  One-cycle strobe qualifying pixel and pixel_addr.
- pixel_addr  output  ADDR_W  Linear address y*H_ACTIVE+x of the current pixel.
- frame_start  output  1  One-cycle pulse when a captured frame begins.
- frame_done  output  1  One-cycle pulse at the end of a captured frame.
- frame_error  output  1  Valid with frame_done; held until the next frame_start.
- capturing  output  1  High in the ARMED and ACTIVE states.

Behaviour:
- Input register stage: cam_vsync, cam_href and cam_data are registered once (vs_r, hr_r, d_r); all decisions use these registered copies.
- Reset: all outputs are 0, state is IDLE, byte phase is 0, all counters are 0.
- Reset asserted mid-frame aborts the frame immediately with no frame_done.
- States:
  - IDLE: capturing=0. If start_capture=1, go to SYNC.
  - SYNC: wait for vs_r=1 (blanking), then go to ARMED. This guarantees capture never starts mid-frame.
  - ARMED: on a vs_r 1->0 edge, pulse frame_start, clear x, y, pixel_addr, byte phase, error and pixel count, then go to ACTIVE.
  - ACTIVE:
    - Each cycle with hr_r=1 toggles the byte phase. Phase 0 latches the high byte; phase 1 forms the pixel.
    - pixel_valid is registered: it goes high on the edge after d_r holds the second byte, i.e. 2 edges after the second byte is on cam_data.
    - After each emitted pixel, pixel_addr and x increment by 1.
    - On an hr_r 1->0 edge, y increments, x clears and phase clears.
    - On a vs_r 0->1 edge, pulse frame_done with frame_error valid in the same cycle. If start_capture=1, go to ARMED; otherwise go to IDLE.
- Boundary conditions:
  - x = H_ACTIVE when a new pixel completes: the pixel is suppressed (no pixel_valid, no address increment) and the error flag is set.
  - y >= V_ACTIVE while hr_r=1: all pixels are suppressed and the error flag is set.
  - HREF falls with phase=1 (odd byte count): the partial byte is discarded and the error flag is set.
  - Short frame (VSYNC rises before H_ACTIVE*V_ACTIVE pixels were emitted): frame_error=1 at frame_done.
  - Any error set during a frame: frame_error=1 at frame_done.
  - start_capture falling mid-frame: the current frame completes normally, then the block returns to IDLE. No truncation.
  - start_capture falling in SYNC or ARMED: return to IDLE immediately.
  - pixel_addr never wraps within a frame because suppression caps it at H_ACTIVE*V_ACTIVE-1.
  - frame_error clears on frame_start. frame_done and frame_start never coincide.
  - HREF high while in IDLE, SYNC or ARMED produces no output.

Test Plan:
- Reset and idle: params H_ACTIVE=4, V_ACTIVE=2. Hold reset 3 cycles, start_capture=0, toggle the bus -> all outputs 0, no pixel_valid.
- Nominal frame: start=1; VSYNC high 4 cycles then low; 2 lines of 8 bytes 0x00..0x0F with 3-cycle HREF gaps; VSYNC high -> 8 pixel_valid strobes:
  - pixel=0x0001,0x0203,...,0x0E0F
  - addr=0..7
  - frame_start once
  - frame_done once with frame_error=0
- Mid-frame start: assert start while HREF is active in the middle of a frame -> no pixels until the next VSYNC fall; the following frame is captured fully (addr 0..7).
- Overflow/odd bytes: a line of 9 bytes -> 4 pixels, extra byte discarded; a 10-byte line -> 5th pixel suppressed; both cases give frame_error=1 at frame_done, cleared at the next frame_start.
- Short frame and stop: VSYNC rises after 1 line -> frame_error=1; start_capture dropped during the next frame -> that frame completes with frame_done, then capturing=0.
- Reset mid-line: assert reset after 3 pixels -> outputs 0 next cycle, no frame_done, state IDLE.
